// File: rtl/frame_stream_tx.sv
// Raster transmitter: pulls pixels from a ready/valid source and emits a
// free-running hvalid/vvalid framed stream with programmable blanking.
module frame_stream_tx #(
    parameter int unsigned H_ACT   = 1920,
    parameter int unsigned H_BLANK = 280,
    parameter int unsigned V_ACT   = 1080,
    parameter int unsigned V_BLANK = 45,
    parameter int unsigned DW      = 8,
    parameter int unsigned HW      = 12,
    parameter int unsigned VW      = 11
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [DW-1:0] s_data,
    input  logic          s_valid,
    output logic          s_ready,
    output logic          vvalid,
    output logic          hvalid,
    output logic [DW-1:0] dout,
    output logic          underflow,
    input  logic          clr_err,
    output logic [15:0]   frame_cnt,
    output logic          busy
);

    localparam int unsigned H_TOT = H_ACT + H_BLANK;

    localparam logic [HW-1:0] H_ACT_LAST   = HW'(H_ACT - 1);
    localparam logic [HW-1:0] H_TOT_LAST   = HW'(H_TOT - 1);
    localparam logic [VW-1:0] V_ACT_LAST   = VW'(V_ACT - 1);
    localparam logic [VW-1:0] V_BLANK_LAST = VW'(V_BLANK - 1);

    localparam logic [1:0] S_IDLE        = 2'd0;
    localparam logic [1:0] S_LINE_ACT    = 2'd1;
    localparam logic [1:0] S_LINE_BLANK  = 2'd2;
    localparam logic [1:0] S_FRAME_BLANK = 2'd3;

    logic [1:0]    r_state;
    logic [HW-1:0] r_hcnt;
    logic [VW-1:0] r_vcnt;
    logic [1:0]    w_state_nxt;
    logic [HW-1:0] w_hcnt_nxt;
    logic [VW-1:0] w_vcnt_nxt;
    logic          w_frame_done;

    logic          r_s_ready;
    logic          r_vact_d;
    logic          r_vvalid;
    logic          r_hvalid;
    logic [DW-1:0] r_dout;
    logic          r_underflow;
    logic [15:0]   r_frame_cnt;
    logic          r_busy;

    // State register: the raster position runs two cycles ahead of hvalid/vvalid.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_hcnt  <= '0;
            r_vcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_hcnt  <= w_hcnt_nxt;
            r_vcnt  <= w_vcnt_nxt;
        end
    end

    // Next-state logic; hcnt spans the whole line, vcnt counts lines within a phase.
    always_comb begin
        w_state_nxt  = r_state;
        w_hcnt_nxt   = r_hcnt;
        w_vcnt_nxt   = r_vcnt;
        w_frame_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (en) begin
                    w_state_nxt = S_LINE_ACT;
                    w_hcnt_nxt  = '0;
                    w_vcnt_nxt  = '0;
                end
            end
            S_LINE_ACT: begin
                w_hcnt_nxt = r_hcnt + HW'(1);
                if (r_hcnt == H_ACT_LAST) begin
                    w_state_nxt = S_LINE_BLANK;
                end
            end
            S_LINE_BLANK: begin
                if (r_hcnt == H_TOT_LAST) begin
                    w_hcnt_nxt = '0;
                    if (r_vcnt < V_ACT_LAST) begin
                        w_state_nxt = S_LINE_ACT;
                        w_vcnt_nxt  = r_vcnt + VW'(1);
                    end else begin
                        w_state_nxt = S_FRAME_BLANK;
                        w_vcnt_nxt  = '0;
                    end
                end else begin
                    w_hcnt_nxt = r_hcnt + HW'(1);
                end
            end
            S_FRAME_BLANK: begin
                if (r_hcnt == H_TOT_LAST) begin
                    w_hcnt_nxt = '0;
                    if (r_vcnt == V_BLANK_LAST) begin
                        w_frame_done = 1'b1;
                        w_vcnt_nxt   = '0;
                        w_state_nxt  = en ? S_LINE_ACT : S_IDLE;
                    end else begin
                        w_vcnt_nxt = r_vcnt + VW'(1);
                    end
                end else begin
                    w_hcnt_nxt = r_hcnt + HW'(1);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output pipeline: s_ready one cycle behind state, hvalid/dout one behind s_ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s_ready   <= 1'b0;
            r_vact_d    <= 1'b0;
            r_vvalid    <= 1'b0;
            r_hvalid    <= 1'b0;
            r_dout      <= '0;
            r_underflow <= 1'b0;
            r_frame_cnt <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_s_ready <= (r_state == S_LINE_ACT);
            r_vact_d  <= (r_state == S_LINE_ACT) || (r_state == S_LINE_BLANK);
            r_vvalid  <= r_vact_d;
            r_hvalid  <= r_s_ready;
            r_busy    <= (r_state != S_IDLE);
            r_dout    <= (r_s_ready && s_valid) ? s_data : '0;
            if (r_s_ready && !s_valid) begin
                r_underflow <= 1'b1;
            end else if (clr_err) begin
                r_underflow <= 1'b0;
            end
            if (w_frame_done) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
        end
    end

    assign s_ready   = r_s_ready;
    assign vvalid    = r_vvalid;
    assign hvalid    = r_hvalid;
    assign dout      = r_dout;
    assign underflow = r_underflow;
    assign frame_cnt = r_frame_cnt;
    assign busy      = r_busy;

endmodule

// File: doc/frame_stream_tx.md
# frame_stream_tx

Raster transmitter for the edge pipeline. It pulls pixels from an upstream ready/valid source, such as a frame-buffer reader or a test-pattern FIFO. It emits them as a free-running hvalid/vvalid framed stream, the format the sobel and non-maximum stages consume. Blanking intervals are programmable. Raster timing never stalls: an upstream underflow inserts zero pixels and raises a sticky error flag.

## Interface
- H_ACT, 1920: active pixels per line.
- H_BLANK, 280: blanking cycles after each active line (≥2).
- V_ACT, 1080: active lines per frame.
- V_BLANK, 45: blank lines after the last active line (≥1); each blank line is H_ACT+H_BLANK cycles.
- DW, 8: pixel width.
- HW, 12: horizontal counter width; must hold H_ACT+H_BLANK-1.
- VW, 11: vertical counter width; must hold max(V_ACT, V_BLANK)-1.
- clk  in  1  pixel clock, all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  run request; sampled at frame boundaries only.
- s_data  in  DW  upstream pixel.
- s_valid  in  1  upstream pixel available.
- s_ready  out  1  pixel accepted this cycle when s_valid & s_ready.
- vvalid  out  1  frame window: high from the first pixel of line 0 to the last blank cycle of line V_ACT-1.
- hvalid  out  1  high for exactly H_ACT consecutive cycles per active line.
- dout  out  DW  pixel; meaningful only while hvalid=1.
- underflow  out  1  sticky; set when a pixel slot found s_valid=0.
- clr_err  in  1  clears underflow.
- frame_cnt  out  16  completed frames, wraps at 0xFFFF→0.
- busy  out  1  state ≠ IDLE.

## Operation
- FSM states: IDLE, LINE_ACT, LINE_BLANK, FRAME_BLANK.
- IDLE → LINE_ACT when en=1. hcnt=vcnt=0 on entry.
- LINE_ACT lasts H_ACT cycles, then goes to LINE_BLANK.
- LINE_BLANK lasts H_BLANK cycles. On exit:
  - vcnt<V_ACT-1 → LINE_ACT, vcnt+1.
  - otherwise → FRAME_BLANK, vcnt=0.
- FRAME_BLANK lasts V_BLANK×(H_ACT+H_BLANK) cycles. At its end:
  - frame_cnt increments.
  - en=1 → LINE_ACT, next frame starts with no gap.
  - en=0 → IDLE.
- en is ignored mid-frame: deasserting it completes the current frame, including FRAME_BLANK.
- Pixel slot: one per LINE_ACT cycle.
  - s_ready is high in the cycle before each slot, i.e. the cycle whose successor is a LINE_ACT cycle.
  - If s_valid=1 in that cycle, s_data is registered to dout for the slot.
  - If s_valid=0, dout=0 for the slot, underflow is set, and no data is consumed.
- s_ready is never high outside those cycles; upstream data is held, not dropped.
- vvalid/hvalid are registered directly from state: no glitches, with a constant relationship to dout.
- clr_err and an underflow event in the same cycle: the set wins.
- hcnt wraps 0..H_ACT+H_BLANK-1; vcnt wraps per phase. The counters never exceed their widths.

## Timing
- Reset values: s_ready=0, vvalid=0, hvalid=0, dout=0, underflow=0, frame_cnt=0, busy=0, state=IDLE.
- rst asserted mid-frame: all outputs take reset values on the next edge; no partial line completes.
- en=1 at edge t in IDLE:
  - busy=1 and s_ready=1 at t+1.
  - vvalid=hvalid=1 and the first pixel on dout at t+2.
- Latency from accepted s_data to dout is 1 cycle.
- Per line: hvalid high H_ACT cycles, low H_BLANK cycles. s_ready leads hvalid by exactly 1 cycle, on both rising and falling edges.
- vvalid falls on the cycle after the last LINE_BLANK cycle of line V_ACT-1.
- vvalid stays low for V_BLANK×(H_ACT+H_BLANK) cycles.
- Frame period: (V_ACT+V_BLANK)×(H_ACT+H_BLANK) cycles.
- frame_cnt updates one cycle after the last FRAME_BLANK cycle.

## Test plan
- H_ACT=4, H_BLANK=2, V_ACT=3, V_BLANK=1, s_valid always 1 with incrementing data 1..12, en held:
  - hvalid pattern is 111100 ×3.
  - vvalid is high 18 cycles, then low 6.
  - dout sequence is 1..12.
  - frame_cnt=1 after 24 cycles; the next frame starts with data 13.
- Same config, s_valid dropped for the 2nd slot of line 1:
  - dout = 5,0,6,7 on that line.
  - underflow=1 and stays set.
  - clr_err pulse clears it.
  - the following frame is unaffected.
- en deasserted during line 1 of frame 0:
  - the frame completes (12 hvalid cycles, FRAME_BLANK included).
  - frame_cnt=1, busy=0, IDLE.
  - s_ready stays 0 afterwards.
- rst pulsed in the middle of line 2:
  - all outputs are 0 the next cycle.
  - with en=1, the restart yields vvalid 2 cycles after rst deasserts and the dout sequence restarts from s_data.
- clr_err and underflow in the same cycle → underflow=1.
- frame_cnt preloaded near 0xFFFF via 65536 short frames (or force) → wraps to 0.
- Default 1920×1080 params, one frame:
  - 2,073,600 hvalid cycles.
  - period 2,475,000 cycles.
  - s_ready/hvalid lead of 1 cycle checked by assertion throughout.
